// File: rtl/riscv_ifetch_buf.sv
// Instruction fetch unit with a small in-order instruction buffer.
// Issues sequential fetches under a credit limit, buffers responses and discards stale ones after a redirect.
module riscv_ifetch_buf #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               mem_req_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  input  logic               mem_gnt_i,
  input  logic               mem_rvalid_i,
  input  logic [INSTR_W-1:0] mem_rdata_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o,
  input  logic               instr_ready_i
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [ADDR_W-1:0]  r_head_pc;
  logic [CNT_W-1:0]   r_outstanding;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_discard;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic               r_started;
  logic [INSTR_W-1:0] r_buf [DEPTH];

  logic [CNT_W:0]     w_credits;
  logic               w_accept;
  logic               w_rsp;
  logic               w_drop;
  logic               w_push;
  logic               w_pop;

  // Every accepted request reserves a buffer slot, so responses can never overflow.
  assign w_credits = {1'b0, r_outstanding} + {1'b0, r_count};

  assign mem_req_o     = r_started & ~redirect_i & (w_credits < (CNT_W+1)'(DEPTH));
  assign mem_addr_o    = r_fetch_pc;
  assign instr_valid_o = (r_count != '0);
  assign instr_o       = instr_valid_o ? r_buf[r_rd_ptr] : '0;
  assign instr_pc_o    = r_head_pc;

  assign w_accept = mem_req_o & mem_gnt_i;
  assign w_rsp    = mem_rvalid_i & (r_outstanding != '0);
  assign w_drop   = w_rsp & (r_discard != '0);
  assign w_push   = w_rsp & ~w_drop & ~redirect_i;
  assign w_pop    = instr_valid_o & instr_ready_i & ~redirect_i;

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_started     <= 1'b0;
      r_fetch_pc    <= RESET_PC;
      r_head_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_count       <= '0;
      r_discard     <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_started     <= 1'b1;
      r_outstanding <= r_outstanding + CNT_W'(w_accept) - CNT_W'(w_rsp);
      if (redirect_i) begin
        // Everything still in flight after this cycle belongs to the abandoned path.
        r_fetch_pc <= redirect_pc_i;
        r_head_pc  <= redirect_pc_i;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_discard  <= r_outstanding - CNT_W'(w_rsp);
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
        if (w_drop)   r_discard  <= r_discard - CNT_W'(1);
        if (w_push)   r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
        if (w_pop) begin
          r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
          r_head_pc <= r_head_pc + ADDR_W'(4);
        end
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

  // NOTE: the buffer storage has no reset; validity comes solely from r_count.
  always_ff @(posedge clk) begin
    if (w_push) r_buf[r_wr_ptr] <= mem_rdata_i;
  end

endmodule

// File: tb/tb_riscv_ifetch_buf.sv
// Directed bench for riscv_ifetch_buf: a vector table for the main flow plus hand sequences
// for redirects, address wrap and mid-operation reset.
module tb_riscv_ifetch_buf;

  typedef struct {
    logic        redirect;
    logic [31:0] rpc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t tbl[$];

  riscv_ifetch_buf dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  function automatic vec_t mk(input logic [31:0] redirect, rpc, gnt, rvalid, rdata, ready,
                              e_req, e_addr, e_valid, e_instr, e_pc);
    vec_t v;
    v.redirect = redirect[0];
    v.rpc      = rpc;
    v.gnt      = gnt[0];
    v.rvalid   = rvalid[0];
    v.rdata    = rdata;
    v.ready    = ready[0];
    v.e_req    = e_req[0];
    v.e_addr   = e_addr;
    v.e_valid  = e_valid[0];
    v.e_instr  = e_instr;
    v.e_pc     = e_pc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs are driven on the falling edge; outputs are compared 1 time unit later.
  task automatic apply(input vec_t v, input string tag);
    redirect_i    = v.redirect;
    redirect_pc_i = v.rpc;
    mem_gnt_i     = v.gnt;
    mem_rvalid_i  = v.rvalid;
    mem_rdata_i   = v.rdata;
    instr_ready_i = v.ready;
    #1;
    check({tag, ".req"},   32'(mem_req_o),     32'(v.e_req));
    check({tag, ".addr"},  mem_addr_o,         v.e_addr);
    check({tag, ".valid"}, 32'(instr_valid_o), 32'(v.e_valid));
    check({tag, ".instr"}, instr_o,            v.e_instr);
    check({tag, ".pc"},    instr_pc_o,         v.e_pc);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset state.
    @(negedge clk);
    #1;
    check("rst.req",   32'(mem_req_o),     32'd0);
    check("rst.addr",  mem_addr_o,         32'd0);
    check("rst.valid", 32'(instr_valid_o), 32'd0);
    check("rst.instr", instr_o,            32'd0);
    check("rst.pc",    instr_pc_o,         32'd0);

    // redirect, rpc, gnt, rvalid, rdata, ready | req, addr, valid, instr, pc
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,               0, 'h0,  0, 0, 0));        // start flag not set yet
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,               1, 'h0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, dat('h0), 0,        1, 'h4,  0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, dat('h4), 0,        1, 'h8,  1, dat('h0), 0)); // 2 cycles after acceptance
    tbl.push_back(mk(0, 0, 1, 1, dat('h8), 0,        1, 'hC,  1, dat('h0), 0));
    tbl.push_back(mk(0, 0, 1, 1, dat('hC), 0,        0, 'h10, 1, dat('h0), 0)); // 4 credits in use
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,               0, 'h10, 1, dat('h0), 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1,               0, 'h10, 1, dat('h0), 0)); // pop frees a credit
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,               1, 'h10, 1, dat('h4), 'h4));
    tbl.push_back(mk(0, 0, 1, 1, dat('h10), 1,       0, 'h14, 1, dat('h4), 'h4)); // push+pop at count 3
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,               1, 'h14, 1, dat('h8), 'h8)); // grant stall
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,               1, 'h14, 1, dat('hC), 'hC));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,               1, 'h14, 1, dat('hC), 'hC));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,               1, 'h14, 1, dat('hC), 'hC));
    tbl.push_back(mk(1, 'h100, 1, 0, 0, 1,           0, 'h18, 1, dat('hC), 'hC)); // redirect, pop dropped
    tbl.push_back(mk(0, 0, 0, 1, dat('h14), 0,       1, 'h100, 0, 0, 'h100));   // stale response dropped
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,               1, 'h100, 0, 0, 'h100));
    tbl.push_back(mk(0, 0, 0, 1, dat('h100), 0,      1, 'h104, 0, 0, 'h100));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,               1, 'h104, 1, dat('h100), 'h100));
    tbl.push_back(mk(0, 0, 0, 1, 32'hDEAD_BEEF, 0,   1, 'h104, 0, 0, 'h104));   // stray response
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,               1, 'h104, 0, 0, 'h104));   // pop when empty
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,               1, 'h104, 0, 0, 'h104));

    reset_n = 1'b1;
    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

    // Back-to-back redirects with two responses outstanding.
    apply(mk(0, 0, 1, 0, 0, 0,                 1, 'h104, 0, 0, 'h104), "b1");
    apply(mk(0, 0, 1, 0, 0, 0,                 1, 'h108, 0, 0, 'h104), "b2");
    apply(mk(1, 'h300, 1, 0, 0, 0,             0, 'h10C, 0, 0, 'h104), "b3");
    apply(mk(1, 'h100, 1, 1, dat('h104), 0,    0, 'h300, 0, 0, 'h300), "b4");
    apply(mk(0, 0, 0, 1, dat('h108), 0,        1, 'h100, 0, 0, 'h100), "b5");
    apply(mk(0, 0, 1, 0, 0, 0,                 1, 'h100, 0, 0, 'h100), "b6");
    apply(mk(0, 0, 0, 1, dat('h100), 0,        1, 'h104, 0, 0, 'h100), "b7");
    apply(mk(0, 0, 0, 0, 0, 0,                 1, 'h104, 1, dat('h100), 'h100), "b8");

    // Address wrap at the top of the address space.
    apply(mk(1, 32'hFFFF_FFFC, 0, 0, 0, 1,     0, 'h104, 1, dat('h100), 'h100), "w1");
    apply(mk(0, 0, 1, 0, 0, 0,                 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC), "w2");
    apply(mk(0, 0, 0, 1, dat(32'hFFFF_FFFC), 0, 1, 'h0, 0, 0, 32'hFFFF_FFFC), "w3");
    apply(mk(0, 0, 0, 0, 0, 1,                 1, 'h0, 1, dat(32'hFFFF_FFFC), 32'hFFFF_FFFC), "w4");
    apply(mk(0, 0, 0, 0, 0, 0,                 1, 'h0, 0, 0, 'h0), "w5");

    // Fill three entries, then reset in the middle of operation.
    apply(mk(0, 0, 1, 0, 0, 0,                 1, 'h0, 0, 0, 'h0), "d1");
    apply(mk(0, 0, 1, 1, dat('h0), 0,          1, 'h4, 0, 0, 'h0), "d2");
    apply(mk(0, 0, 1, 1, dat('h4), 0,          1, 'h8, 1, dat('h0), 'h0), "d3");
    apply(mk(0, 0, 0, 1, dat('h8), 0,          1, 'hC, 1, dat('h0), 'h0), "d4");
    apply(mk(0, 0, 0, 0, 0, 0,                 1, 'hC, 1, dat('h0), 'h0), "d5");

    reset_n = 1'b0;
    #1;
    check("mrst.req",   32'(mem_req_o),     32'd0);
    check("mrst.addr",  mem_addr_o,         32'd0);
    check("mrst.valid", 32'(instr_valid_o), 32'd0);
    check("mrst.instr", instr_o,            32'd0);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    apply(mk(0, 0, 0, 1, 32'hDEAD_BEEF, 0,     0, 'h0, 0, 0, 'h0), "r1");
    apply(mk(0, 0, 0, 1, 32'hDEAD_BEEF, 0,     1, 'h0, 0, 0, 'h0), "r2");
    apply(mk(0, 0, 0, 0, 0, 0,                 1, 'h0, 0, 0, 'h0), "r3");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
